// File: rtl/cordic_bus_pkg.sv
// Shared register map, control/IRQ bit positions and bus FSM states for the CORDIC APB bridge.
package cordic_bus_pkg;

   localparam logic [4:0] ADDR_X_IN  = 5'h00;
   localparam logic [4:0] ADDR_Y_IN  = 5'h04;
   localparam logic [4:0] ADDR_Z_IN  = 5'h08;
   localparam logic [4:0] ADDR_CTRL  = 5'h0C;
   localparam logic [4:0] ADDR_X_RES = 5'h10;
   localparam logic [4:0] ADDR_Y_RES = 5'h14;
   localparam logic [4:0] ADDR_Z_RES = 5'h18;
   localparam logic [4:0] ADDR_IRQ   = 5'h1C;

   // Word indices used by the decoder (byte offset without the two alignment bits).
   localparam logic [2:0] REG_X_IN  = ADDR_X_IN[4:2];
   localparam logic [2:0] REG_Y_IN  = ADDR_Y_IN[4:2];
   localparam logic [2:0] REG_Z_IN  = ADDR_Z_IN[4:2];
   localparam logic [2:0] REG_CTRL  = ADDR_CTRL[4:2];
   localparam logic [2:0] REG_X_RES = ADDR_X_RES[4:2];
   localparam logic [2:0] REG_Y_RES = ADDR_Y_RES[4:2];
   localparam logic [2:0] REG_Z_RES = ADDR_Z_RES[4:2];
   localparam logic [2:0] REG_IRQ   = ADDR_IRQ[4:2];

   localparam int CTRL_START    = 0;
   localparam int CTRL_SOFT_RST = 31;

   localparam int IRQ_PENDING = 0;
   localparam int IRQ_ENABLE  = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      RESPOND = 2'd2
   } bus_state_e;

endpackage

// File: rtl/cordic_irq_ctrl.sv
// Interrupt front end: rising-edge detect on the core's level interrupt, sticky pending bit
// with write-one-to-clear, enable bit and a registered host irq.
module cordic_irq_ctrl
   import cordic_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst_ni,
   input  logic       interrupt_i,
   input  logic       wr_en_i,
   input  logic [1:0] wdata_i,
   output logic       pending_o,
   output logic       enable_o,
   output logic       rise_o,
   output logic       irq_o
);

   logic dly_q;
   logic pending_q, pending_d;
   logic enable_q, enable_d;
   logic irq_q;

   assign rise_o = interrupt_i & ~dly_q;

   always_comb begin
      pending_d = pending_q;
      enable_d  = enable_q;
      if (wr_en_i) begin
         enable_d = wdata_i[IRQ_ENABLE];
         if (wdata_i[IRQ_PENDING]) begin
            pending_d = 1'b0;
         end
      end
      // A new edge in the same cycle as a clear keeps the event.
      if (rise_o) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         dly_q     <= 1'b0;
         pending_q <= 1'b0;
         enable_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         dly_q     <= interrupt_i;
         pending_q <= pending_d;
         enable_q  <= enable_d;
         irq_q     <= pending_q & enable_q;
      end
   end

   assign pending_o = pending_q;
   assign enable_o  = enable_q;
   assign irq_o     = irq_q;

endmodule

// File: rtl/cordic_apb_bridge.sv
// APB register bridge in front of the CORDIC core: operand/control shadows, result readback,
// START pulse and soft-reset timer. Optional macro CORDIC_RESULT_SNAPSHOT_EN latches results on irq edges.
module cordic_apb_bridge
   import cordic_bus_pkg::*;
#(
   parameter int p_WIDTH           = 32,
   parameter int p_ADDR_WIDTH      = 5,
   parameter int p_SOFT_RST_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [p_ADDR_WIDTH-1:0] paddr,
   input  logic [p_WIDTH-1:0]      pwdata,
   output logic [p_WIDTH-1:0]      prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic [p_WIDTH-1:0]      xInput,
   output logic [p_WIDTH-1:0]      yInput,
   output logic [p_WIDTH-1:0]      zInput,
   output logic [p_WIDTH-1:0]      controlRegisterInput,
   output logic                    coreClk,
   output logic                    coreRst,
   input  logic [p_WIDTH-1:0]      xResult,
   input  logic [p_WIDTH-1:0]      yResult,
   input  logic [p_WIDTH-1:0]      zResult,
   input  logic [p_WIDTH-1:0]      controlRegisterOutput,
   input  logic [p_WIDTH-1:0]      controlRegisterMask,
   input  logic                    interrupt,
   output logic                    irq
);

   localparam int CNT_W = $clog2(p_SOFT_RST_CYCLES + 1);

   bus_state_e              state_q, state_d;
   logic [p_ADDR_WIDTH-1:0] addr_q;
   logic [p_WIDTH-1:0]      wdata_q;
   logic                    write_q;
   logic [p_WIDTH-1:0]      x_q, y_q, z_q;
   logic [p_WIDTH-1:0]      ctrl_q, ctrl_d, ctrl_view;
   logic [p_WIDTH-1:0]      prdata_q, prdata_d, rd_data;
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [CNT_W-1:0]        soft_cnt_q, soft_cnt_d;
   logic                    soft_active, soft_load;
   logic                    capture, addr_err, wr_en, irq_wr;
   logic [2:0]              reg_sel;
   logic                    irq_pending, irq_enable, irq_rise;
   logic [p_WIDTH-1:0]      res_live [3];
   logic [p_WIDTH-1:0]      res_view [3];

   assign res_live[0] = xResult;
   assign res_live[1] = yResult;
   assign res_live[2] = zResult;

`ifdef CORDIC_RESULT_SNAPSHOT_EN
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_snap
         logic [p_WIDTH-1:0] snap_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               snap_q <= '0;
            end else if (irq_rise) begin
               snap_q <= res_live[gi];
            end
         end
         assign res_view[gi] = snap_q;
      end
   endgenerate
`else
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_live
         assign res_view[gi] = res_live[gi];
      end
   endgenerate
   logic unused_rise;
   assign unused_rise = irq_rise;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (psel && penable) state_d = CAPTURE;
         CAPTURE: state_d = RESPOND;
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      capture  = (state_q == CAPTURE);
      reg_sel  = addr_q[4:2];
      addr_err = (addr_q[1:0] != 2'b00) ||
                 (write_q && ((reg_sel == REG_X_RES) || (reg_sel == REG_Y_RES) ||
                              (reg_sel == REG_Z_RES)));
      wr_en    = capture && write_q && !addr_err;

      rd_data = '0;
      case (reg_sel)
         REG_X_IN:  rd_data = x_q;
         REG_Y_IN:  rd_data = y_q;
         REG_Z_IN:  rd_data = z_q;
         REG_CTRL:  rd_data = (controlRegisterOutput & controlRegisterMask) |
                              (ctrl_view & ~controlRegisterMask);
         REG_X_RES: rd_data = res_view[0];
         REG_Y_RES: rd_data = res_view[1];
         REG_Z_RES: rd_data = res_view[2];
         REG_IRQ: begin
            rd_data[IRQ_PENDING] = irq_pending;
            rd_data[IRQ_ENABLE]  = irq_enable;
         end
         default:   rd_data = '0;
      endcase

      pready_d  = capture;
      pslverr_d = capture && addr_err;
      prdata_d  = prdata_q;
      if (capture) begin
         prdata_d = (write_q || addr_err) ? '0 : rd_data;
      end
   end

   assign irq_wr = wr_en && (reg_sel == REG_IRQ);

   // START lives one cycle in the shadow; SOFT_RST is never stored, only the timer is.
   always_comb begin
      ctrl_d             = ctrl_q;
      ctrl_d[CTRL_START] = 1'b0;
      soft_load          = 1'b0;
      if (wr_en && (reg_sel == REG_CTRL)) begin
         ctrl_d                = (ctrl_q & controlRegisterMask) | (wdata_q & ~controlRegisterMask);
         ctrl_d[CTRL_SOFT_RST] = 1'b0;
         soft_load             = wdata_q[CTRL_SOFT_RST] & ~controlRegisterMask[CTRL_SOFT_RST];
      end
      soft_cnt_d = soft_cnt_q;
      if (soft_load) begin
         soft_cnt_d = CNT_W'(p_SOFT_RST_CYCLES);
      end else if (soft_cnt_q != '0) begin
         soft_cnt_d = soft_cnt_q - CNT_W'(1);
      end
   end

   always_comb begin
      ctrl_view                = ctrl_q;
      ctrl_view[CTRL_SOFT_RST] = soft_active;
   end

   assign soft_active = (soft_cnt_q != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         write_q    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         ctrl_q     <= '0;
         soft_cnt_q <= '0;
         prdata_q   <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
      end else begin
         if ((state_q == IDLE) && psel && penable) begin
            addr_q  <= paddr;
            wdata_q <= pwdata;
            write_q <= pwrite;
         end
         if (wr_en && (reg_sel == REG_X_IN)) x_q <= wdata_q;
         if (wr_en && (reg_sel == REG_Y_IN)) y_q <= wdata_q;
         if (wr_en && (reg_sel == REG_Z_IN)) z_q <= wdata_q;
         ctrl_q     <= ctrl_d;
         soft_cnt_q <= soft_cnt_d;
         prdata_q   <= prdata_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
      end
   end

   cordic_irq_ctrl u_irq (
      .clk         (clk),
      .rst_ni      (rst),
      .interrupt_i (interrupt),
      .wr_en_i     (irq_wr),
      .wdata_i     (wdata_q[1:0]),
      .pending_o   (irq_pending),
      .enable_o    (irq_enable),
      .rise_o      (irq_rise),
      .irq_o       (irq)
   );

   assign prdata               = prdata_q;
   assign pready               = pready_q;
   assign pslverr              = pslverr_q;
   assign xInput               = x_q;
   assign yInput               = y_q;
   assign zInput               = z_q;
   assign controlRegisterInput = ctrl_view;
   assign coreClk              = clk;
   assign coreRst              = rst & ~soft_active;

endmodule

// File: doc/cordic_apb_bridge.md
Name: cordic_apb_bridge

Overview:
- Bus-side endpoint of the CORDIC accelerator's bus interface: drives the bus modport (xInput, yInput, zInput, controlRegisterInput, clk, rst) and consumes xResult, yResult, zResult, controlRegisterOutput, controlRegisterMask and interrupt.
- Exposes these signals to the host as an APB-style memory-mapped register file.
- Adds a sticky, maskable interrupt, a self-clearing start pulse and a soft-reset generator.
- Sits between the SoC interconnect and the CORDIC controller.

Parameters:
p_WIDTH, 32, data width of the bus, the CORDIC operands and the register file
p_ADDR_WIDTH, 5, byte-address width (8 word registers)
p_SOFT_RST_CYCLES, 4, number of cycles the core reset is held low after a soft reset

Ports:
clk  input  1  system clock; also forwarded to the core as coreClk
rst  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  p_ADDR_WIDTH  byte address
pwdata  input  p_WIDTH  write data
prdata  output  p_WIDTH  read data
pready  output  1  transfer complete (registered)
pslverr  output  1  transfer error, valid when pready=1
xInput/yInput/zInput  output  p_WIDTH each  signed operands to the core
controlRegisterInput  output  p_WIDTH  control word to the core
coreClk  output  1  equal to clk
coreRst  output  1  active-low core reset = rst AND NOT softRstActive
xResult/yResult/zResult  input  p_WIDTH each  signed core results
controlRegisterOutput  input  p_WIDTH  core-owned control/status bits
controlRegisterMask  input  p_WIDTH  1 = bit owned by the core
interrupt  input  1  core completion, level
irq  output  1  host interrupt = irqPending AND irqEnable

Behaviour:
- Reset (rst low, asynchronous), all cleared to 0:
  - operand and control shadows, prdata, pready, pslverr
  - irqPending, irqEnable, interruptDly
  - FSM state returns to IDLE and the soft-reset counter is cleared.
  - coreRst follows rst low immediately.
- Register map (word offsets):
  - 0x00 X_IN, 0x04 Y_IN, 0x08 Z_IN: RW, drive the operand outputs directly.
  - 0x0C CTRL: read returns (controlRegisterOutput & mask) | (shadow & ~mask). A write updates shadow bits only where mask=0.
  - 0x10 X_RES, 0x14 Y_RES, 0x18 Z_RES: RO.
  - 0x1C IRQ: bit0 pending (W1C), bit1 enable (RW); other bits read 0.
- CTRL bit0 is START:
  - controlRegisterInput[0] = 1 for exactly one cycle, the cycle after the write completes; the shadow bit then self-clears.
  - CTRL bit31 is SOFT_RST: a write of 1 loads a counter with p_SOFT_RST_CYCLES and coreRst is held low while the counter is nonzero. The bit reads back 1 while the counter runs.
  - Writing SOFT_RST=1 again mid-count reloads the counter.
- FSM: IDLE -> CAPTURE -> RESPOND -> IDLE.
  - IDLE: on psel & penable, latch the address/data and go to CAPTURE; pready=0.
  - CAPTURE: decode the address. Writes update the target register; reads latch read data into prdata. Set pslverr_next. Go to RESPOND.
  - RESPOND: pready=1 and pslverr valid for one cycle, then IDLE.
  - Latency: pready asserts on the 3rd cycle of the access phase, so both reads and writes have 2 wait states.
  - If psel drops mid-transfer, the FSM completes its sequence and the response is discarded. The bus may not start a new transfer before pready.
- Errors (pslverr=1, no state change, prdata=0):
  - paddr[1:0] != 0
  - write to 0x10–0x18
- Interrupt:
  - interruptDly registers the interrupt input.
  - On a rising edge (interrupt & ~interruptDly), irqPending <= 1.
  - If a W1C of pending and a rising edge occur in the same cycle, set wins and pending stays 1.
  - irq is a registered output: it rises one cycle after pending & enable becomes true.
- Soft reset does not clear the bridge's own registers.

Optional Feature:
- Macro: CORDIC_RESULT_SNAPSHOT_EN.
- Defined: on the interrupt rising edge, xResult, yResult and zResult are latched into snapshot registers, and 0x10–0x18 read the snapshots (stable until the next edge).
- Undefined: 0x10–0x18 read the live inputs, captured in CAPTURE; no snapshot flops exist.

Decomposition:
- Package cordic_bus_pkg:
  - register offset localparams (ADDR_X_IN … ADDR_IRQ)
  - CTRL bit indices (CTRL_START=0, CTRL_SOFT_RST=31)
  - IRQ bit indices
  - FSM state enum (IDLE, CAPTURE, RESPOND)
- One natural sub-module, cordic_irq_ctrl: edge detect, sticky pending, enable, W1C, irq register.

Test Plan:
- Write 0x00=0x0000_4000, then read 0x00 -> pready on 3rd access cycle, prdata=0x0000_4000, pslverr=0, xInput=0x0000_4000.
- Write CTRL=0x1 -> controlRegisterInput[0] high exactly one cycle; subsequent CTRL read bit0=0.
- Mask=0x0000_FF00, controlRegisterOutput=0x0000_AB00, write CTRL=0x0000_12F0 -> read returns 0x0000_ABF0.
- Enable irq (write 0x1C=0x2), pulse interrupt -> pending=1, irq high next cycle; write 0x1C=0x3 with a simultaneous new edge -> pending stays 1.
- Write 0x10 or read 0x02 -> pslverr=1, registers unchanged, prdata=0.
- Write CTRL bit31 -> coreRst low for 4 cycles, then high; with the snapshot macro defined, changing xResult after the interrupt edge does not change the 0x10 read value.
